sample_serializer: RTL and testbench

//   Downstream stage of the ADC sample path. Captures valid ADC samples on selected

---
 rtl/sample_serializer_pkg.sv | 36 +++
 rtl/sample_fifo.sv | 57 +++++
 rtl/sample_serializer.sv | 133 +++++++++++++
 tb/tb_sample_serializer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_serializer_pkg.sv
// Shared definitions for the sample serializer: frame field widths, sync marker, FSM states.
// SAMPLE_SERIALIZER_CHECKSUM_EN adds the checksum byte states.
package sample_serializer_pkg;

    localparam int unsigned CH_W     = 4;
    localparam int unsigned SAMPLE_W = 10;
    localparam int unsigned ENTRY_W  = CH_W + SAMPLE_W;
    localparam int unsigned SYNC_BIT = 7;
    localparam logic [7:0]  DROP_CNT_MAX = 8'd255;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSendHi = 3'd1,
        StGapHi  = 3'd2,
        StSendLo = 3'd3,
        StGapLo  = 3'd4
`ifdef SAMPLE_SERIALIZER_CHECKSUM_EN
        ,
        StSendCk = 3'd5,
        StGapCk  = 3'd6
`endif
    } state_e;

    // First byte of a frame carries the sync marker, channel and top sample bits.
    function automatic logic [7:0] frame_hi(input logic [ENTRY_W-1:0] entry);
        logic [7:0] b;
        b = {1'b0, entry[ENTRY_W-1:SAMPLE_W], entry[SAMPLE_W-1:7]};
        b[SYNC_BIT] = 1'b1;
        return b;
    endfunction

    function automatic logic [7:0] frame_lo(input logic [ENTRY_W-1:0] entry);
        return {1'b0, entry[6:0]};
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with occupancy count; pushes while full and pops while empty are ignored.
module sample_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 14,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LVL_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    // Storage needs no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/sample_serializer.sv
// Filters ADC samples by channel, buffers them and streams 2-byte frames to the UART.
// Define SAMPLE_SERIALIZER_CHECKSUM_EN for a third (checksum) byte per frame.
module sample_serializer
    import sample_serializer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter logic [15:0] CHANNEL_MASK = 16'h0001,
    localparam int unsigned LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               new_sample,
    input  logic [9:0]         sample,
    input  logic [3:0]         sample_channel,
    output logic [7:0]         tx_data,
    output logic               new_tx_data,
    input  logic               tx_block,
    output logic               overflow,
    output logic [7:0]         drop_count,
    output logic [LVL_W-1:0]   fifo_level
);

    logic               accept, push, pop, drop;
    logic               full, empty;
    logic [ENTRY_W-1:0] fifo_rdata;

    state_e             state_q, state_d;
    logic [ENTRY_W-1:0] entry_q, entry_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               new_tx_data_q, new_tx_data_d;
    logic               overflow_q;
    logic [7:0]         drop_q;
    logic [7:0]         hi_byte, lo_byte;

    assign accept = new_sample & CHANNEL_MASK[sample_channel];
    // A full FIFO drops the push even if the FSM pops in the same cycle.
    assign push   = accept & ~full;
    assign drop   = accept & full;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({sample_channel, sample}),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_q != DROP_CNT_MAX) drop_q <= drop_q + 8'd1;
        end
    end

    assign hi_byte = frame_hi(entry_q);
    assign lo_byte = frame_lo(entry_q);

    always_comb begin
        state_d       = state_q;
        entry_d       = entry_q;
        tx_data_d     = tx_data_q;
        new_tx_data_d = 1'b0;
        pop           = 1'b0;
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    entry_d = fifo_rdata;
                    state_d = StSendHi;
                end
            end
            StSendHi: begin
                if (!tx_block) begin
                    tx_data_d     = hi_byte;
                    new_tx_data_d = 1'b1;
                    state_d       = StGapHi;
                end
            end
            StGapHi: state_d = StSendLo;
            StSendLo: begin
                if (!tx_block) begin
                    tx_data_d     = lo_byte;
                    new_tx_data_d = 1'b1;
                    state_d       = StGapLo;
                end
            end
`ifdef SAMPLE_SERIALIZER_CHECKSUM_EN
            StGapLo: state_d = StSendCk;
            StSendCk: begin
                if (!tx_block) begin
                    tx_data_d     = {1'b0, hi_byte[6:0] ^ lo_byte[6:0]};
                    new_tx_data_d = 1'b1;
                    state_d       = StGapCk;
                end
            end
            StGapCk: state_d = StIdle;
`else
            StGapLo: state_d = StIdle;
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            entry_q       <= '0;
            tx_data_q     <= '0;
            new_tx_data_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            entry_q       <= entry_d;
            tx_data_q     <= tx_data_d;
            new_tx_data_q <= new_tx_data_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign new_tx_data = new_tx_data_q;
    assign overflow    = overflow_q;
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_sample_serializer.sv
// Scoreboard bench for sample_serializer: directed corner cases plus randomized traffic.
module tb_sample_serializer;

`ifdef SAMPLE_SERIALIZER_CHECKSUM_EN
    localparam int BYTES = 3;
`else
    localparam int BYTES = 2;
`endif

    typedef struct {
        logic [7:0] b;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       new_sample = 1'b0;
    logic [9:0] sample = '0;
    logic [3:0] sample_channel = '0;
    logic       tx_block = 1'b0;
    logic [7:0] tx_data;
    logic       new_tx_data;
    logic       overflow;
    logic [7:0] drop_count;
    logic [4:0] fifo_level;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          strobes = 0;
    int          cyc = 0;
    logic [15:0] mask = 16'h0001;

    sample_serializer dut (
        .clk            (clk),
        .rst            (rst),
        .new_sample     (new_sample),
        .sample         (sample),
        .sample_channel (sample_channel),
        .tx_data        (tx_data),
        .new_tx_data    (new_tx_data),
        .tx_block       (tx_block),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .fifo_level     (fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    // Monitor: every strobe must match the next expected byte (and cycle when timed).
    initial begin
        logic prev_strobe;
        logic prev_block;
        exp_t e;
        prev_strobe = 1'b0;
        prev_block  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && new_tx_data) begin
                check("back_to_back_strobe", int'(prev_strobe), 0);
                check("strobe_while_blocked", int'(prev_block), 0);
                check("strobe_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("tx_byte", int'(tx_data), int'(e.b));
                    if (e.cyc >= 0) check("strobe_cycle", cyc, e.cyc);
                end
                strobes++;
            end
            prev_strobe = rst ? 1'b0 : new_tx_data;
            prev_block  = rst ? 1'b0 : tx_block;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one sample for one cycle; model frames it if its channel is enabled.
    task automatic send(input logic [3:0] ch, input logic [9:0] s, input bit expect_out,
                        input bit timed);
        logic [7:0] hi, lo;
        int         t0;
        t0             = cyc;
        new_sample     = 1'b1;
        sample         = s;
        sample_channel = ch;
        if (mask[ch] && expect_out) begin
            hi = 8'(128 + int'(ch) * 8 + int'(s) / 128);
            lo = 8'(int'(s) % 128);
            exp_q.push_back('{hi, timed ? t0 + 3 : -1});
            exp_q.push_back('{lo, timed ? t0 + 5 : -1});
            if (BYTES == 3) exp_q.push_back('{8'((int'(hi) % 128) ^ int'(lo)), timed ? t0 + 7 : -1});
        end
        @(posedge clk);
        #1;
        new_sample = 1'b0;
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int n;
        n = 0;
        while (strobes < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("strobe_wait_timeout", int'(strobes >= target), 1);
    endtask

    task automatic drain(input int budget, input bit rnd);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tx_block = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        tx_block = 1'b0;
        tick(4);
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tx_data"}, int'(tx_data), 0);
        check({tag, "_new_tx_data"}, int'(new_tx_data), 0);
        check({tag, "_overflow"}, int'(overflow), 0);
        check({tag, "_drop_count"}, int'(drop_count), 0);
        check({tag, "_fifo_level"}, int'(fifo_level), 0);
    endtask

    task automatic do_reset(input string tag);
        rst        = 1'b1;
        new_sample = 1'b0;
        tx_block   = 1'b0;
        @(negedge clk);
        check_zero(tag);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(2);
    endtask

    initial begin
        int t0, base, n;
        logic [3:0] ch;

        // Reset state
        tick(2);
        check_zero("reset");
        rst = 1'b0;
        tick(2);

        // Single frame latency and exact bytes
        t0 = cyc;
        exp_q.push_back('{8'h85, t0 + 3});
        exp_q.push_back('{8'h25, t0 + 5});
        if (BYTES == 3) exp_q.push_back('{8'h20, t0 + 7});
        send(4'd0, 10'h2A5, 1'b0, 1'b0);
        tick(20);
        check("t1_queue_empty", exp_q.size(), 0);

        // Non-masked channel ignored
        send(4'd3, 10'h155, 1'b1, 1'b0);
        tick(1);
        check("t2_level", int'(fifo_level), 0);
        check("t2_drop", int'(drop_count), 0);
        tick(10);

        // Fill while blocked, one drop, then drain in order
        tx_block = 1'b1;
        send(4'd0, 10'($urandom_range(0, 1023)), 1'b1, 1'b0);
        tick(3);
        check("t3_first_latched_level", int'(fifo_level), 0);
        for (int i = 0; i < 17; i++) send(4'd0, 10'($urandom_range(0, 1023)), i < 16, 1'b0);
        check("t3_level_full", int'(fifo_level), 16);
        check("t3_overflow", int'(overflow), 1);
        check("t3_drop", int'(drop_count), 1);
        drain(1000, 1'b0);
        check("t3_level_after", int'(fifo_level), 0);

        // Push and pop in the same cycle at level 5
        do_reset("t4_reset");
        tx_block = 1'b1;
        send(4'd0, 10'($urandom_range(0, 1023)), 1'b1, 1'b0);
        tick(3);
        for (int i = 0; i < 5; i++) send(4'd0, 10'($urandom_range(0, 1023)), 1'b1, 1'b0);
        check("t4_level5", int'(fifo_level), 5);
        base = strobes;
        tx_block = 1'b0;
        wait_strobes(base + BYTES, 60);
        @(posedge clk);
        #1;
        send(4'd0, 10'($urandom_range(0, 1023)), 1'b1, 1'b0);
        check("t4_push_pop_level", int'(fifo_level), 5);
        drain(1000, 1'b0);

        // Drop counter saturation
        do_reset("t4b_reset");
        tx_block = 1'b1;
        for (int i = 0; i < 317; i++) begin
            send(4'd0, 10'($urandom_range(0, 1023)), 1'b0, 1'b0);
            if (i == 270) check("t4_drop_254", int'(drop_count), 254);
        end
        check("t4_drop_sat", int'(drop_count), 255);
        check("t4_overflow", int'(overflow), 1);
        check("t4_level", int'(fifo_level), 16);

        // Reset between HI and LO abandons the frame
        do_reset("t5_pre");
        base = strobes;
        send(4'd0, 10'($urandom_range(0, 1023)), 1'b1, 1'b0);
        wait_strobes(base + 1, 20);
        @(posedge clk);
        #1;
        do_reset("t5_midframe");
        tick(12);
        check("t5_no_more_strobes", strobes, base + 1);

        // Randomized bursts, at most 10 accepted per burst so the FIFO never overflows
        for (int b = 0; b < 15; b++) begin
            n = 0;
            for (int i = 0; i < 24 && n < 10; i++) begin
                tx_block = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 1) == 1) begin
                    ch = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(1, 15));
                    if (mask[ch]) n++;
                    send(ch, 10'($urandom_range(0, 1023)), 1'b1, 1'b0);
                end else begin
                    tick(1);
                end
            end
            drain(3000, 1'b1);
        end
        check("rand_drop", int'(drop_count), 0);
        check("rand_overflow", int'(overflow), 0);
        check("rand_level", int'(fifo_level), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
